// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default datapath width.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Behavioural 1-bit full-adder cell used as the single arithmetic element of the serial adder.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, carry held in a flop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; sum/carry_out hold the last result
//   ST_SHIFT | adding one bit per clock, busy=1
//   ST_DONE  | one-cycle done pulse; a new start here is accepted
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic             fa_s, fa_c;
    logic             accept;
    logic             last;

    serial_adder_fa u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (cy),
        .sum       (fa_s),
        .carry_out (fa_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // Accepting here gives back-to-back adds with no idle gap.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            cy   <= carry_in;
            cnt  <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= {fa_s, s_sr[WIDTH-1:1]};
            cy   <= fa_c;
            cnt  <= cnt + CNT_W'(1);
            // Result registers only move on the final bit, never partially.
            if (last) begin
                sum       <= {fa_s, s_sr[WIDTH-1:1]};
                carry_out <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit directed cases plus exhaustive 4-bit sweep, scoreboarded.
module tb_serial_adder;

    typedef struct {
        logic [31:0] res;
        int          due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    sb_t         q8[$];
    sb_t         q4[$];
    logic [31:0] hold8 = '0;
    logic [31:0] hold4 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with u8 able to accept; returns one negedge later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        sb_t e;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        e.res = 32'({1'b0, a} + {1'b0, b} + 9'(cin));
        e.due = edge_cnt + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // An aborting reset discards whatever was in flight.
    always @(posedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q4.delete();
            hold8 = '0;
            hold4 = '0;
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (done8) begin
            if (q8.size() == 0) chk("u8_unexpected_done", 32'(1), 32'(0));
            else begin
                e = q8.pop_front();
                chk("u8_done_edge", 32'(edge_cnt), 32'(e.due));
                chk("u8_result", 32'({cout8, sum8}), e.res);
                hold8 = e.res;
            end
        end else begin
            chk("u8_hold", 32'({cout8, sum8}), hold8);
            if (q8.size() != 0 && edge_cnt > q8[0].due) begin
                chk("u8_done_timeout", 32'(edge_cnt), 32'(q8[0].due));
                void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (done4) begin
            if (q4.size() == 0) chk("u4_unexpected_done", 32'(1), 32'(0));
            else begin
                e = q4.pop_front();
                chk("u4_done_edge", 32'(edge_cnt), 32'(e.due));
                chk("u4_result", 32'({cout4, sum4}), e.res);
                hold4 = e.res;
            end
        end else begin
            chk("u4_hold", 32'({cout4, sum4}), hold4);
            if (q4.size() != 0 && edge_cnt > q4[0].due) begin
                chk("u4_done_timeout", 32'(edge_cnt), 32'(q4[0].due));
                void'(q4.pop_front());
            end
        end
    end

    initial begin
        int   nbusy;
        sb_t  e;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'(0));
        chk("rst_done", 32'(done8), 32'(0));
        chk("rst_sum", 32'(sum8), 32'(0));
        chk("rst_cout", 32'(cout8), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add, busy exactly WIDTH cycles, then back to idle
        issue8(8'h3C, 8'h42, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy8) nbusy++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(nbusy), 32'(8));
        chk("idle_busy", 32'(busy8), 32'(0));
        chk("idle_done", 32'(done8), 32'(0));

        // Overflow into carry_out
        issue8(8'hFF, 8'h01, 1'b0);
        repeat (9) @(negedge clk);
        issue8(8'hA5, 8'h5A, 1'b1);
        repeat (9) @(negedge clk);

        // Start pulse mid-add must be ignored
        issue8(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        chk("midadd_busy", 32'(busy8), 32'(1));
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (9) @(negedge clk);

        // Back-to-back with start held through done
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        e.res = 32'h002; e.due = edge_cnt + 1 + 8;  q8.push_back(e);
        e.res = 32'h030; e.due = edge_cnt + 1 + 17; q8.push_back(e);
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20;
        repeat (9) @(negedge clk);
        start8 = 1'b0;
        chk("b2b_second_busy", 32'(busy8), 32'(1));
        repeat (10) @(negedge clk);

        // Reset during the 4th bit aborts the add
        issue8(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy8), 32'(0));
        chk("abort_done", 32'(done8), 32'(0));
        chk("abort_sum", 32'(sum8), 32'(0));
        chk("abort_cout", 32'(cout8), 32'(0));
        repeat (12) @(negedge clk);
        issue8(8'hC8, 8'h64, 1'b0);
        repeat (10) @(negedge clk);

        // 4-bit exhaustive, back-to-back
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
            e.res = 32'({1'b0, a4} + {1'b0, b4} + 5'(cin4));
            e.due = edge_cnt + 1 + 4;
            q4.push_back(e);
            repeat (5) @(negedge clk);
        end
        start4 = 1'b0;
        repeat (8) @(negedge clk);

        chk("q8_drained", 32'(q8.size()), 32'(0));
        chk("q4_drained", 32'(q4.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
